// File: rtl/vga_fbuff_pkg.sv
// Shared definitions for the VGA frame-buffer line path.
//   - fbuff_state_e : states of the line reader FSM
//   - *_DEF         : default geometry of the frame buffer and line buffer
//   - pixel packing : PIXELS_PER_WORD pixels of PIXEL_WIDTH bits per word
package vga_fbuff_pkg;

    localparam int FBUFF_ADDR_WIDTH_DEF = 12;
    localparam int FBUFF_WIDTH_DEF      = 60;
    localparam int FBUFF_DEPTH_DEF      = 3840;
    localparam int WORDS_PER_LINE_DEF   = 16;
    localparam int RSP_TIMEOUT_DEF      = 15;
    localparam int PIXELS_PER_WORD      = 20;
    localparam int PIXEL_WIDTH          = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } fbuff_state_e;

endpackage

// File: rtl/fbuff_line_reader.sv
// Fetches one display line (WORDS_PER_LINE words) from the frame buffer into an
// external line buffer, one word at a time.
//
// Ports
//   clk_i, rstn_i       : clock, asynchronous active-low reset
//   frame_start_i       : restart reading at address 0 (deferred while busy)
//   line_req_i          : start fetching the next line
//   rd_req_o            : one-cycle read request per word
//   rd_rsp_i            : read response; fbuff_data_i valid while high
//   fbuff_addr_o/en_o   : frame buffer address and enable
//   fbuff_data_i        : frame buffer read data
//   lbuff_we_o/addr_o/data_o : line buffer write port
//   busy_o              : line fetch in progress
//   line_done_o         : pulse when the line has been written
//   ovr_o               : pulse when line_req_i arrives while busy
//   tout_o              : pulse when a word's response timed out
//
// Handshake: rd_req_o is high for exactly one cycle per word. The address and
// enable stay stable from that cycle until the response (rd_rsp_i sampled high
// in WAIT_RSP) or the timeout is taken. rd_rsp_i at any other time is ignored.
module fbuff_line_reader
    import vga_fbuff_pkg::*;
#(
    parameter int FBUFF_ADDR_WIDTH = FBUFF_ADDR_WIDTH_DEF,
    parameter int FBUFF_WIDTH      = FBUFF_WIDTH_DEF,
    parameter int FBUFF_DEPTH      = FBUFF_DEPTH_DEF,
    parameter int WORDS_PER_LINE   = WORDS_PER_LINE_DEF,
    parameter int RSP_TIMEOUT      = RSP_TIMEOUT_DEF
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              frame_start_i,
    input  logic                              line_req_i,
    output logic                              rd_req_o,
    input  logic                              rd_rsp_i,
    output logic [FBUFF_ADDR_WIDTH-1:0]       fbuff_addr_o,
    output logic                              fbuff_en_o,
    input  logic [FBUFF_WIDTH-1:0]            fbuff_data_i,
    output logic                              lbuff_we_o,
    output logic [$clog2(WORDS_PER_LINE)-1:0] lbuff_addr_o,
    output logic [FBUFF_WIDTH-1:0]            lbuff_data_o,
    output logic                              busy_o,
    output logic                              line_done_o,
    output logic                              ovr_o,
    output logic                              tout_o
);

    localparam int LB_AW = $clog2(WORDS_PER_LINE);
    localparam int TW    = $clog2(RSP_TIMEOUT + 1);

    localparam logic [LB_AW-1:0]            LAST_WORD = LB_AW'(WORDS_PER_LINE - 1);
    localparam logic [FBUFF_ADDR_WIDTH-1:0] LAST_ADDR = FBUFF_ADDR_WIDTH'(FBUFF_DEPTH - 1);
    // The REQ cycle counts as the first of the RSP_TIMEOUT cycles.
    localparam logic [TW-1:0]               TOUT_LAST = TW'(RSP_TIMEOUT - 1);

    fbuff_state_e                  state_q, state_d;
    logic [FBUFF_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LB_AW-1:0]              word_cnt_q, word_cnt_d;
    logic [TW-1:0]                 tcnt_q, tcnt_d;
    logic                          fs_pend_q, fs_pend_d;
    logic                          rd_req_q, rd_req_d;
    logic                          fbuff_en_q, fbuff_en_d;
    logic                          lbuff_we_q, lbuff_we_d;
    logic [LB_AW-1:0]              lbuff_addr_q, lbuff_addr_d;
    logic [FBUFF_WIDTH-1:0]        lbuff_data_q, lbuff_data_d;
    logic                          busy_q, busy_d;
    logic                          line_done_q, line_done_d;
    logic                          ovr_q, ovr_d;
    logic                          tout_q, tout_d;
    logic                          rsp_taken;
    logic                          timed_out;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        word_cnt_d   = word_cnt_q;
        tcnt_d       = tcnt_q;
        fs_pend_d    = fs_pend_q;
        lbuff_addr_d = lbuff_addr_q;
        lbuff_data_d = lbuff_data_q;
        lbuff_we_d   = 1'b0;
        tout_d       = 1'b0;
        rsp_taken    = 1'b0;
        timed_out    = 1'b0;

        // A frame start during a fetch must not disturb the line in flight;
        // remember it and apply it when the line is finished.
        if ((state_q == REQ || state_q == WAIT_RSP) && frame_start_i) begin
            fs_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    addr_d = '0;
                end
                if (line_req_i) begin
                    state_d    = REQ;
                    word_cnt_d = '0;
                end
            end
            REQ: begin
                state_d = WAIT_RSP;
                tcnt_d  = TW'(1);
            end
            WAIT_RSP: begin
                if (rd_rsp_i) begin
                    rsp_taken = 1'b1;
                end else if (tcnt_q == TOUT_LAST) begin
                    timed_out = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                // A timed-out word is written as zeros and the line carries on.
                if (rsp_taken || timed_out) begin
                    lbuff_we_d   = 1'b1;
                    lbuff_addr_d = word_cnt_q;
                    lbuff_data_d = rsp_taken ? fbuff_data_i : '0;
                    tout_d       = timed_out;
                    addr_d       = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    word_cnt_d   = word_cnt_q + 1'b1;
                    state_d      = (word_cnt_q == LAST_WORD) ? DONE : REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (fs_pend_q || frame_start_i) begin
                    addr_d = '0;
                end
                fs_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs follow the state being entered.
        rd_req_d    = (state_d == REQ);
        fbuff_en_d  = (state_d == REQ) || (state_d == WAIT_RSP);
        busy_d      = (state_d == REQ) || (state_d == WAIT_RSP);
        line_done_d = (state_d == DONE);
        ovr_d       = line_req_i && (state_q != IDLE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            word_cnt_q   <= '0;
            tcnt_q       <= '0;
            fs_pend_q    <= 1'b0;
            rd_req_q     <= 1'b0;
            fbuff_en_q   <= 1'b0;
            lbuff_we_q   <= 1'b0;
            lbuff_addr_q <= '0;
            lbuff_data_q <= '0;
            busy_q       <= 1'b0;
            line_done_q  <= 1'b0;
            ovr_q        <= 1'b0;
            tout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            word_cnt_q   <= word_cnt_d;
            tcnt_q       <= tcnt_d;
            fs_pend_q    <= fs_pend_d;
            rd_req_q     <= rd_req_d;
            fbuff_en_q   <= fbuff_en_d;
            lbuff_we_q   <= lbuff_we_d;
            lbuff_addr_q <= lbuff_addr_d;
            lbuff_data_q <= lbuff_data_d;
            busy_q       <= busy_d;
            line_done_q  <= line_done_d;
            ovr_q        <= ovr_d;
            tout_q       <= tout_d;
        end
    end

    // The address register only changes when a word is retired, so it is
    // already stable from REQ until the response is taken.
    assign rd_req_o     = rd_req_q;
    assign fbuff_addr_o = fbuff_en_q ? addr_q : '0;
    assign fbuff_en_o   = fbuff_en_q;
    assign lbuff_we_o   = lbuff_we_q;
    assign lbuff_addr_o = lbuff_addr_q;
    assign lbuff_data_o = lbuff_data_q;
    assign busy_o       = busy_q;
    assign line_done_o  = line_done_q;
    assign ovr_o        = ovr_q;
    assign tout_o       = tout_q;

endmodule

// File: tb/tb_fbuff_line_reader.sv
module tb_fbuff_line_reader;

    localparam int AW          = 12;
    localparam int DW          = 60;
    localparam int DEPTH       = 3840;
    localparam int WPL         = 16;
    localparam int RSP_TIMEOUT = 15;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rstn_i;
    always #5 clk_i = ~clk_i;

    logic          frame_start_i, line_req_i, rd_rsp_i;
    logic [DW-1:0] fbuff_data_i;
    logic          rd_req_o, fbuff_en_o, lbuff_we_o, busy_o, line_done_o, ovr_o, tout_o;
    logic [AW-1:0] fbuff_addr_o;
    logic [3:0]    lbuff_addr_o;
    logic [DW-1:0] lbuff_data_o;

    fbuff_line_reader dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .frame_start_i(frame_start_i), .line_req_i(line_req_i),
        .rd_req_o(rd_req_o), .rd_rsp_i(rd_rsp_i),
        .fbuff_addr_o(fbuff_addr_o), .fbuff_en_o(fbuff_en_o), .fbuff_data_i(fbuff_data_i),
        .lbuff_we_o(lbuff_we_o), .lbuff_addr_o(lbuff_addr_o), .lbuff_data_o(lbuff_data_o),
        .busy_o(busy_o), .line_done_o(line_done_o), .ovr_o(ovr_o), .tout_o(tout_o)
    );

    wire [23:0] outs_flat = {rd_req_o, fbuff_en_o, fbuff_addr_o, lbuff_we_o, lbuff_addr_o,
                             |lbuff_data_o, busy_o, line_done_o, ovr_o, tout_o};

    // ---------------- scoreboard / counters ----------------
    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int req_cnt = 0, tout_cnt = 0, ovr_cnt = 0, done_cnt = 0, wr_cnt = 0;
    int last_req_cyc = 0, tout_gap = 0, done_cyc = 0;
    int model_addr = 0;     // next frame buffer address the reference expects
    int silent_addr = -1;   // responder ignores requests to this address
    int rsp_lat = 2;
    int pend_cnt = 0;
    logic [DW-1:0] pend_data;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // Frame buffer responder: answers each request after rsp_lat cycles with
    // data equal to the requested address; stray responses while idle.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            pend_cnt = 0;
            rd_rsp_i = 1'b0;
        end else begin
            rd_rsp_i     = 1'b0;
            fbuff_data_i = {$urandom, $urandom};
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    rd_rsp_i     = 1'b1;
                    fbuff_data_i = pend_data;
                end
            end else if (!busy_o && $urandom_range(0, 7) == 0) begin
                rd_rsp_i = 1'b1;
            end
            if (rd_req_o && int'(fbuff_addr_o) != silent_addr) begin
                pend_cnt  = rsp_lat;
                pend_data = DW'(fbuff_addr_o);
            end
        end
    end

    // Monitor: event counters and line buffer write checking.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (tout_o) begin
                tout_cnt++;
                tout_gap = cyc - last_req_cyc;
            end
            if (rd_req_o) begin
                req_cnt++;
                last_req_cyc = cyc;
            end
            if (ovr_o) ovr_cnt++;
            if (line_done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (lbuff_we_o) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("wr_unexpected", {63'd0, lbuff_we_o}, 64'd0);
                end else begin
                    check_eq("lbuff_write", {lbuff_addr_o, lbuff_data_o}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_frame_start();
        @(negedge clk_i);
        frame_start_i = 1'b1;
        @(negedge clk_i);
        frame_start_i = 1'b0;
        model_addr = 0;
    endtask

    // Fetch one line. *_w arguments give the number of words already written
    // when the event happens (-1 = never). fs_with_req raises frame_start_i
    // together with line_req_i.
    task automatic do_line(input int silent_w, input int fs_w, input int ovr_w,
                           input int rst_w, input int lat, input bit fs_with_req);
        int base, exp_lat, req0, ovr0, tout0, done0, wr0, n_wr, t0;
        bit fs_sent, ovr_sent, clr, did_rst;
        logic [DW-1:0] d;
        fs_sent = 0; ovr_sent = 0; clr = 0; did_rst = 0;
        if (fs_with_req) model_addr = 0;
        base        = model_addr;
        rsp_lat     = lat;
        silent_addr = (silent_w >= 0) ? (base + silent_w) % DEPTH : -1;
        exp_lat     = 1;
        for (int w = 0; w < WPL; w++) begin
            exp_lat += (w == silent_w) ? RSP_TIMEOUT : lat + 1;
            if (rst_w < 0 || w < rst_w) begin
                d = (w == silent_w) ? '0 : DW'((base + w) % DEPTH);
                exp_q.push_back({4'(w), d});
            end
        end
        req0 = req_cnt; ovr0 = ovr_cnt; tout0 = tout_cnt; done0 = done_cnt; wr0 = wr_cnt;

        @(negedge clk_i);
        line_req_i    = 1'b1;
        frame_start_i = fs_with_req;
        t0 = cyc;
        @(negedge clk_i);
        line_req_i    = 1'b0;
        frame_start_i = 1'b0;
        check_eq("busy_set", {63'd0, busy_o}, 64'd1);

        for (int i = 0; i < 600 && done_cnt == done0 && !did_rst; i++) begin
            @(negedge clk_i);
            #1;
            if (clr) begin
                line_req_i = 1'b0; frame_start_i = 1'b0; clr = 0;
            end
            n_wr = wr_cnt - wr0;
            if (fs_w >= 0 && !fs_sent && n_wr == fs_w) begin
                frame_start_i = 1'b1; fs_sent = 1; clr = 1;
            end
            if (ovr_w >= 0 && !ovr_sent && n_wr == ovr_w) begin
                line_req_i = 1'b1; ovr_sent = 1; clr = 1;
            end
            if (rst_w >= 0 && n_wr == rst_w) begin
                line_req_i = 1'b0; frame_start_i = 1'b0;
                rstn_i = 1'b0;
                #1;
                check_eq("rst_outs_zero", 64'(outs_flat), 64'd0);
                did_rst = 1;
            end
        end
        if (clr) begin
            @(negedge clk_i);
            line_req_i = 1'b0; frame_start_i = 1'b0;
        end

        if (did_rst) begin
            repeat (3) @(negedge clk_i);
            check_eq("rst_hold_zero", 64'(outs_flat), 64'd0);
            check_eq("rst_no_done", done_cnt - done0, 0);
            check_eq("rst_words_left", exp_q.size(), 0);
            exp_q.delete();
            model_addr  = 0;
            silent_addr = -1;
            @(negedge clk_i);
            rstn_i = 1'b1;
            repeat (2) @(negedge clk_i);
            return;
        end

        check_eq("line_done_cnt", done_cnt - done0, 1);
        check_eq("done_latency", done_cyc - t0, exp_lat);
        check_eq("rd_req_cnt", req_cnt - req0, WPL);
        check_eq("tout_cnt", tout_cnt - tout0, (silent_w >= 0) ? 1 : 0);
        if (silent_w >= 0) check_eq("tout_gap", tout_gap, RSP_TIMEOUT);
        check_eq("ovr_cnt", ovr_cnt - ovr0, (ovr_w >= 0) ? 1 : 0);
        repeat (6) @(negedge clk_i);
        check_eq("idle_busy", {63'd0, busy_o}, 64'd0);
        check_eq("no_extra_req", req_cnt - req0, WPL);
        check_eq("sb_empty", exp_q.size(), 0);
        model_addr  = (fs_w >= 0) ? 0 : (base + WPL) % DEPTH;
        silent_addr = -1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sil, fs, ov;
        rstn_i = 1'b0; frame_start_i = 1'b0; line_req_i = 1'b0;
        rd_rsp_i = 1'b0; fbuff_data_i = '0;
        repeat (3) @(negedge clk_i);
        check_eq("reset_outs", 64'(outs_flat), 64'd0);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);

        pulse_frame_start();
        do_line(-1, -1, -1, -1, 2, 0);           // words 0..15, done at 49
        do_line(-1, -1,  5, -1, 2, 0);           // overrun at word 5
        do_line( 3, -1, -1, -1, 2, 0);           // word 3 times out

        pulse_frame_start();
        do_line(-1, -1, -1, -1, 2, 0);
        do_line(-1, -1, -1, -1, 2, 0);
        do_line(-1,  8, -1, -1, 2, 0);           // 32..47, then restart
        do_line(-1, -1, -1, -1, 2, 0);           // 0..15

        pulse_frame_start();
        for (int l = 0; l < 240; l++) do_line(-1, -1, -1, -1, 2, 0);
        do_line(-1, -1, -1, -1, 2, 0);           // wrapped to 0..15

        do_line(-1, -1, -1, 10, 2, 0);           // reset at word 10
        do_line(-1, -1, -1, -1, 2, 0);           // 0..15 after reset

        do_line(-1, -1, -1, -1, 2, 1);           // frame start with request

        for (int l = 0; l < 24; l++) begin
            sil = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            fs  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1;
            ov  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1;
            if ($urandom_range(0, 4) == 0) pulse_frame_start();
            do_line(sil, fs, ov, -1, int'($urandom_range(2, 8)), $urandom_range(0, 5) == 0);
            repeat ($urandom_range(0, 5)) @(negedge clk_i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
